seven_segment_seconds: RTL and testbench



---
 rtl/seven_segment_seconds.sv | 110 +++++++++++
 tb/tb_seven_segment_seconds.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/seven_segment_seconds.sv
`default_nettype none
// ============================================================================
//  Module      : seven_segment_seconds
//  Description : 2x2 signed matrix multiplier tile, C = A x B.
//                Operands are four 2-bit two's-complement elements each.
//                A arrives on ui_in and B arrives on uio_in. Both are captured
//                together while the block is idle. The four 5-bit results are
//                then streamed out on uo_out, one tagged element per clock.
//  Ports       : clk     - system clock, rising edge
//                rst_n   - asynchronous active-low reset
//                ena     - design enable; 0 freezes all state
//                ui_in   - matrix A {a00,a01,a10,a11}, 2 bits each
//                uio_in  - matrix B {b00,b01,b10,b11}, 2 bits each
//                uo_out  - {index[1:0], valid, value[4:0]}
//                uio_out - always 8'h00
//                uio_oe  - always 8'h00 (uio pins are inputs only)
//  Revision    : 1.0 - initial release
// ============================================================================
module seven_segment_seconds (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_COMPUTE = 2'd1;
  localparam logic [1:0] c_OUT     = 2'd2;

  logic [1:0]      r_state;
  logic [7:0]      r_a;
  logic [7:0]      r_b;
  logic [3:0][4:0] r_c;    // [0]=c00 [1]=c01 [2]=c10 [3]=c11
  logic [1:0]      r_idx;
  logic [7:0]      r_uo;

  // Sign-extend a 2-bit element so that products and sums computed in
  // 5 bits are exact. The result range of -4..+8 fits in 5-bit signed.
  function automatic logic signed [4:0] sx(input logic [1:0] v);
    return {{3{v[1]}}, v};
  endfunction

  logic signed [4:0] w_a00, w_a01, w_a10, w_a11;
  logic signed [4:0] w_b00, w_b01, w_b10, w_b11;
  logic signed [4:0] w_c00, w_c01, w_c10, w_c11;

  assign w_a00 = sx(r_a[7:6]);
  assign w_a01 = sx(r_a[5:4]);
  assign w_a10 = sx(r_a[3:2]);
  assign w_a11 = sx(r_a[1:0]);
  assign w_b00 = sx(r_b[7:6]);
  assign w_b01 = sx(r_b[5:4]);
  assign w_b10 = sx(r_b[3:2]);
  assign w_b11 = sx(r_b[1:0]);

  assign w_c00 = w_a00 * w_b00 + w_a01 * w_b10;
  assign w_c01 = w_a00 * w_b01 + w_a01 * w_b11;
  assign w_c10 = w_a10 * w_b00 + w_a11 * w_b10;
  assign w_c11 = w_a10 * w_b01 + w_a11 * w_b11;

  // uo_out is registered, so it lags the state by one edge. The element for
  // r_idx is presented on the edge that leaves that OUT step. The output
  // returns to 00 on the following IDLE capture edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= '0;
      r_idx   <= '0;
      r_uo    <= '0;
    end else if (ena) begin
      case (r_state)
        c_IDLE: begin
          r_a     <= ui_in;
          r_b     <= uio_in;
          r_uo    <= '0;
          r_state <= c_COMPUTE;
        end
        c_COMPUTE: begin
          r_c     <= {w_c11, w_c10, w_c01, w_c00};
          r_idx   <= '0;
          r_uo    <= '0;
          r_state <= c_OUT;
        end
        c_OUT: begin
          r_uo  <= {r_idx, 1'b1, r_c[r_idx]};
          r_idx <= r_idx + 2'd1;
          if (r_idx == 2'd3) begin
            r_state <= c_IDLE;
          end
        end
        default: begin
          r_uo    <= '0;
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  assign uo_out  = r_uo;
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule
`default_nettype wire

// File: tb/tb_seven_segment_seconds.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seven_segment_seconds
//  Description : Scoreboard testbench for the 2x2 signed matrix multiplier.
//                The stimulus pushes hand-computed output bytes into a queue.
//                A negedge monitor pops and compares each valid output, and
//                it checks idle zeros and enable-low holds.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seven_segment_seconds;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic       ena_q = 1'b0;
  logic [7:0] last_uo = 8'h00;

  seven_segment_seconds dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  // Record the enable value that the DUT used at each rising edge.
  always @(posedge clk) ena_q <= ena;

  // Monitor process
  always @(negedge clk) begin
    if (rst_n) begin
      if (!ena_q) begin
        checks++;
        if (uo_out !== last_uo) begin
          errors++;
          $display("FAIL hold: uo_out=%02h required=%02h", uo_out, last_uo);
        end
      end else if (uo_out[5]) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: uo_out=%02h required=none", uo_out);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (uo_out !== e) begin
            errors++;
            $display("FAIL element: uo_out=%02h required=%02h", uo_out, e);
          end
        end
      end else begin
        checks++;
        if (uo_out !== 8'h00) begin
          errors++;
          $display("FAIL idle_zero: uo_out=%02h required=00", uo_out);
        end
      end
    end
    last_uo = uo_out;
  end

  // One 6-cycle frame. This task must be called while the DUT is in IDLE.
  // The drop argument removes ena for 3 cycles right after c01 appears.
  // The chg argument changes the operands mid-OUT to AA/55.
  task automatic frame(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] e0, input logic [7:0] e1,
                       input logic [7:0] e2, input logic [7:0] e3,
                       input bit drop, input bit chg);
    ui_in  = a;
    uio_in = b;
    exp_q.push_back(e0);
    exp_q.push_back(e1);
    exp_q.push_back(e2);
    exp_q.push_back(e3);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (chg && k == 2) begin
        ui_in  = 8'hAA;
        uio_in = 8'h55;
      end
      if (drop && k == 3) begin
        ena = 1'b0;
        repeat (3) begin
          @(posedge clk); #1;
        end
        ena = 1'b1;
      end
    end
  endtask

  task automatic check_tie(input string name);
    checks++;
    if (uo_out !== 8'h00 || uio_oe !== 8'h00 || uio_out !== 8'h00) begin
      errors++;
      $display("FAIL %s: uo_out=%02h uio_oe=%02h uio_out=%02h required=00/00/00",
               name, uo_out, uio_oe, uio_out);
    end
  endtask

  initial begin
    // Reset checks
    #3 check_tie("reset_initial");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Basic product, identity, and the two extreme cases
    frame(8'h6E, 8'hD5, 8'h3D, 8'h7F, 8'hBF, 8'hFD, 1'b0, 1'b0);
    frame(8'h41, 8'h9C, 8'h3E, 8'h61, 8'hBF, 8'hE0, 1'b0, 1'b0);
    frame(8'hAA, 8'hAA, 8'h28, 8'h68, 8'hA8, 8'hE8, 1'b0, 1'b0);
    frame(8'hAA, 8'h55, 8'h3C, 8'h7C, 8'hBC, 8'hFC, 1'b0, 1'b0);

    // Enable drop after c01 appears
    frame(8'h6E, 8'hD5, 8'h3D, 8'h7F, 8'hBF, 8'hFD, 1'b1, 1'b0);

    // Operands change during OUT. The following frame must use AA/55.
    frame(8'h41, 8'h9C, 8'h3E, 8'h61, 8'hBF, 8'hE0, 1'b0, 1'b1);
    frame(8'hAA, 8'h55, 8'h3C, 8'h7C, 8'hBC, 8'hFC, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a frame, just after c00 appears
    ui_in  = 8'h6E;
    uio_in = 8'hD5;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_tie("reset_midframe");
    exp_q.delete();
    @(negedge clk); #1;
    rst_n = 1'b1;

    // A clean frame after the aborted one
    frame(8'h6E, 8'hD5, 8'h3D, 8'h7F, 8'hBF, 8'hFD, 1'b0, 1'b0);
    @(negedge clk); #1;

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drained: pending=%0d required=0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
